// File: rtl/int_pkg.sv
// Shared definitions for the CPU-side interrupt sequencer and its controller:
// sequencer states, C_IRQ field positions and the number of interrupt sources.
package int_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ACK      = 3'd1,
    ST_DISPATCH = 3'd2,
    ST_SERVICE  = 3'd3,
    ST_END      = 3'd4
  } state_e;

  localparam int IRQ_PEND = 1;
  localparam int IRQ_SRC  = 0;
  localparam int NUM_SRC  = 2;
  localparam int SRC_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

endpackage

// File: rtl/int_cpu_sequencer.sv
// CPU end of the interrupt handshake: takes a pending request at an instruction
// boundary, acknowledges it, dispatches to the source vector and signals end of service.
module int_cpu_sequencer
  import int_pkg::*;
#(
  parameter int                ADDR_W        = 16,
  parameter logic [ADDR_W-1:0] VECTOR_BASE   = 16'h0004,
  parameter int                VECTOR_STRIDE = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [1:0]        C_IRQ,
  output logic              C_IACK,
  output logic              C_IEND,
  input  logic              INT_EN_SET,
  input  logic              INT_EN_CLR,
  input  logic              INSTR_BOUNDARY,
  input  logic [ADDR_W-1:0] PC_IN,
  input  logic              RETI,
  output logic              TAKE_INT,
  output logic [ADDR_W-1:0] VECTOR,
  output logic              RESTORE,
  output logic [ADDR_W-1:0] SAVED_PC,
  output logic              IN_SERVICE,
  output logic              INT_EN,
  output logic [2:0]        dbg_state
);

  localparam logic [ADDR_W-1:0] STRIDE_W = ADDR_W'(VECTOR_STRIDE);

  state_e             state_q, state_d;
  logic [SRC_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]  saved_pc_q, saved_pc_d;
  logic [ADDR_W-1:0]  vector_q, vector_d;
  logic               int_en_q, int_en_d;
  logic               c_iack_q, c_iack_d;
  logic               c_iend_q, c_iend_d;
  logic               take_int_q, take_int_d;
  logic               restore_q, restore_d;
  logic               in_service_q, in_service_d;

  // Pulse outputs are decoded from the state being entered, so each one is
  // registered and lines up with the state it belongs to.
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    saved_pc_d   = saved_pc_q;
    vector_d     = vector_q;
    int_en_d     = int_en_q;
    c_iack_d     = 1'b0;
    c_iend_d     = 1'b0;
    take_int_d   = 1'b0;
    restore_d    = 1'b0;
    in_service_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Entry uses the enable as it stood before this cycle's set/clear.
        if (C_IRQ[IRQ_PEND] && int_en_q && INSTR_BOUNDARY) begin
          state_d    = ST_ACK;
          src_d      = SRC_W'(C_IRQ[IRQ_SRC]);
          saved_pc_d = PC_IN;
          int_en_d   = 1'b0;
          c_iack_d   = 1'b1;
        end else if (INT_EN_CLR) begin
          int_en_d = 1'b0;
        end else if (INT_EN_SET) begin
          int_en_d = 1'b1;
        end
      end
      ST_ACK: begin
        state_d    = ST_DISPATCH;
        take_int_d = 1'b1;
        vector_d   = VECTOR_BASE + ADDR_W'(src_q) * STRIDE_W;
      end
      ST_DISPATCH: begin
        state_d      = ST_SERVICE;
        in_service_d = 1'b1;
      end
      ST_SERVICE: begin
        if (RETI) begin
          state_d   = ST_END;
          c_iend_d  = 1'b1;
          restore_d = 1'b1;
          int_en_d  = 1'b1;
        end else begin
          in_service_d = 1'b1;
        end
      end
      ST_END: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      src_q        <= '0;
      saved_pc_q   <= '0;
      vector_q     <= '0;
      int_en_q     <= 1'b0;
      c_iack_q     <= 1'b0;
      c_iend_q     <= 1'b0;
      take_int_q   <= 1'b0;
      restore_q    <= 1'b0;
      in_service_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      saved_pc_q   <= saved_pc_d;
      vector_q     <= vector_d;
      int_en_q     <= int_en_d;
      c_iack_q     <= c_iack_d;
      c_iend_q     <= c_iend_d;
      take_int_q   <= take_int_d;
      restore_q    <= restore_d;
      in_service_q <= in_service_d;
    end
  end

  assign C_IACK     = c_iack_q;
  assign C_IEND     = c_iend_q;
  assign TAKE_INT   = take_int_q;
  assign VECTOR     = vector_q;
  assign RESTORE    = restore_q;
  assign SAVED_PC   = saved_pc_q;
  assign IN_SERVICE = in_service_q;
  assign INT_EN     = int_en_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_int_cpu_sequencer.sv
// Bench for int_cpu_sequencer: a directed handshake table, a few hand-written
// corner sequences and a random run, all compared to a timeline-based model.
module tb_int_cpu_sequencer;

  localparam int ADDR_W = 16;
  localparam int BASE_A = 'h0004;
  localparam int BASE_B = 'hFFFC;
  localparam int STRIDE = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        c_irq;
  logic              int_en_set, int_en_clr, instr_boundary, reti;
  logic [ADDR_W-1:0] pc_in;

  logic              iack_a, iend_a, take_a, restore_a, svc_a, en_a;
  logic [ADDR_W-1:0] vec_a, saved_a;
  logic [2:0]        dbg_a;
  logic              iack_b, iend_b, take_b, restore_b, svc_b, en_b;
  logic [ADDR_W-1:0] vec_b, saved_b;
  logic [2:0]        dbg_b;

  always #5 clk = ~clk;

  int_cpu_sequencer #(.ADDR_W(ADDR_W), .VECTOR_BASE(16'h0004), .VECTOR_STRIDE(STRIDE)) dut_a (
    .CLK(clk), .RESET(reset), .C_IRQ(c_irq), .C_IACK(iack_a), .C_IEND(iend_a),
    .INT_EN_SET(int_en_set), .INT_EN_CLR(int_en_clr), .INSTR_BOUNDARY(instr_boundary),
    .PC_IN(pc_in), .RETI(reti), .TAKE_INT(take_a), .VECTOR(vec_a), .RESTORE(restore_a),
    .SAVED_PC(saved_a), .IN_SERVICE(svc_a), .INT_EN(en_a), .dbg_state(dbg_a)
  );

  int_cpu_sequencer #(.ADDR_W(ADDR_W), .VECTOR_BASE(16'hFFFC), .VECTOR_STRIDE(STRIDE)) dut_b (
    .CLK(clk), .RESET(reset), .C_IRQ(c_irq), .C_IACK(iack_b), .C_IEND(iend_b),
    .INT_EN_SET(int_en_set), .INT_EN_CLR(int_en_clr), .INSTR_BOUNDARY(instr_boundary),
    .PC_IN(pc_in), .RETI(reti), .TAKE_INT(take_b), .VECTOR(vec_b), .RESTORE(restore_b),
    .SAVED_PC(saved_b), .IN_SERVICE(svc_b), .INT_EN(en_b), .dbg_state(dbg_b)
  );

  int checks = 0;
  int errors = 0;

  // Model: cycle n is the count of rising edges seen. An accepted request at
  // edge e and an accepted RETI at edge r fix the whole pulse timeline.
  int                n = 0;
  bit                m_busy = 0;
  int                m_e = -100;
  int                m_r = -1;
  bit                m_en = 0;
  bit                m_src = 0;
  logic [ADDR_W-1:0] m_saved = '0;
  logic [ADDR_W-1:0] m_vec_a = '0;
  logic [ADDR_W-1:0] m_vec_b = '0;

  task automatic model_step();
    bit idle_before;
    n++;
    if (reset) begin
      m_busy = 0; m_e = -100; m_r = -1; m_en = 0;
      m_saved = '0; m_vec_a = '0; m_vec_b = '0;
      return;
    end
    idle_before = !m_busy;
    if (m_busy && m_r >= 0 && n == m_r + 1) begin
      m_busy = 0;
    end else if (m_busy && m_r < 0 && n - 1 >= m_e + 2 && reti) begin
      m_r  = n;
      m_en = 1;
    end
    if (idle_before) begin
      if (c_irq[1] && m_en && instr_boundary) begin
        m_busy = 1; m_e = n; m_r = -1; m_src = c_irq[0]; m_saved = pc_in; m_en = 0;
      end else if (int_en_clr) begin
        m_en = 0;
      end else if (int_en_set) begin
        m_en = 1;
      end
    end
    if (m_busy && n == m_e + 1) begin
      m_vec_a = ADDR_W'(BASE_A + int'(m_src) * STRIDE);
      m_vec_b = ADDR_W'(BASE_B + int'(m_src) * STRIDE);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d actual %0h required %0h", name, n, act, exp);
    end
  endtask

  task automatic check_model();
    bit e_iend;
    e_iend = (n == m_r);
    chk("m_iack",    32'(iack_a),    32'(n == m_e));
    chk("m_take",    32'(take_a),    32'(n == m_e + 1));
    chk("m_svc",     32'(svc_a),     32'(m_busy && m_r < 0 && n >= m_e + 2));
    chk("m_iend",    32'(iend_a),    32'(e_iend));
    chk("m_restore", 32'(restore_a), 32'(e_iend));
    chk("m_int_en",  32'(en_a),      32'(m_en));
    chk("m_vector",  32'(vec_a),     32'(m_vec_a));
    chk("m_saved",   32'(saved_a),   32'(m_saved));
    chk("m_vector_b", 32'(vec_b),    32'(m_vec_b));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic drive(input logic rst, input logic [1:0] irq, input logic set, input logic clr,
                       input logic bnd, input logic [ADDR_W-1:0] pc, input logic ret);
    reset = rst; c_irq = irq; int_en_set = set; int_en_clr = clr;
    instr_boundary = bnd; pc_in = pc; reti = ret;
  endtask

  typedef struct {
    logic              rst;
    logic [1:0]        irq;
    logic              set, clr, bnd;
    logic [ADDR_W-1:0] pc;
    logic              ret;
    logic              e_iack, e_take, e_svc, e_iend, e_en;
    logic [ADDR_W-1:0] e_vec, e_saved;
  } vec_t;

  vec_t tbl[18];
  int   iack_cnt;

  initial begin
    drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, '0, 1'b0);

    //           rst irq    set clr bnd pc        ret iack take svc iend en  vec       saved
    tbl[0]  = '{1, 2'b00, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000};
    tbl[1]  = '{0, 2'b00, 1, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000};
    tbl[2]  = '{0, 2'b10, 0, 0, 1, 16'h0120, 0, 1, 0, 0, 0, 0, 16'h0000, 16'h0120};
    tbl[3]  = '{0, 2'b00, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 0, 0, 16'h0004, 16'h0120};
    tbl[4]  = '{0, 2'b00, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 16'h0004, 16'h0120};
    tbl[5]  = '{0, 2'b00, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 1, 1, 16'h0004, 16'h0120};
    tbl[6]  = '{0, 2'b00, 0, 0, 1, 16'h0000, 0, 0, 0, 0, 0, 1, 16'h0004, 16'h0120};
    tbl[7]  = '{0, 2'b11, 0, 0, 1, 16'h0200, 0, 1, 0, 0, 0, 0, 16'h0004, 16'h0200};
    tbl[8]  = '{0, 2'b10, 0, 0, 1, 16'h0210, 0, 0, 1, 0, 0, 0, 16'h0008, 16'h0200};
    tbl[9]  = '{0, 2'b10, 1, 0, 1, 16'h0220, 0, 0, 0, 1, 0, 0, 16'h0008, 16'h0200};
    tbl[10] = '{0, 2'b10, 0, 0, 1, 16'h0230, 1, 0, 0, 0, 1, 1, 16'h0008, 16'h0200};
    tbl[11] = '{0, 2'b10, 0, 0, 1, 16'h0240, 0, 0, 0, 0, 0, 1, 16'h0008, 16'h0200};
    tbl[12] = '{0, 2'b10, 0, 0, 1, 16'h0300, 0, 1, 0, 0, 0, 0, 16'h0008, 16'h0300};
    tbl[13] = '{0, 2'b00, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 0, 0, 16'h0004, 16'h0300};
    tbl[14] = '{0, 2'b00, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 16'h0004, 16'h0300};
    tbl[15] = '{1, 2'b00, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000};
    tbl[16] = '{0, 2'b00, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000};
    tbl[17] = '{0, 2'b00, 1, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000};

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].rst, tbl[i].irq, tbl[i].set, tbl[i].clr, tbl[i].bnd, tbl[i].pc, tbl[i].ret);
      step();
      chk($sformatf("t%0d_iack", i),    32'(iack_a),    32'(tbl[i].e_iack));
      chk($sformatf("t%0d_take", i),    32'(take_a),    32'(tbl[i].e_take));
      chk($sformatf("t%0d_svc", i),     32'(svc_a),     32'(tbl[i].e_svc));
      chk($sformatf("t%0d_iend", i),    32'(iend_a),    32'(tbl[i].e_iend));
      chk($sformatf("t%0d_restore", i), 32'(restore_a), 32'(tbl[i].e_iend));
      chk($sformatf("t%0d_int_en", i),  32'(en_a),      32'(tbl[i].e_en));
      chk($sformatf("t%0d_vector", i),  32'(vec_a),     32'(tbl[i].e_vec));
      chk($sformatf("t%0d_saved", i),   32'(saved_a),   32'(tbl[i].e_saved));
    end

    // Idle with enable on and no request: nothing but INT_EN may move.
    drive(1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 16'h0400, 1'b0);
    step();
    int_en_set = 1'b0;
    iack_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      pc_in = ADDR_W'($urandom);
      step();
      if (iack_a || take_a || svc_a || iend_a || restore_a) iack_cnt++;
    end
    chk("quiet_idle_activity", 32'(iack_cnt), 32'd0);
    chk("quiet_idle_int_en", 32'(en_a), 32'd1);

    // Enable cleared: a pending request must sit untaken.
    drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
    step();
    drive(1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 16'h0500, 1'b0);
    iack_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (iack_a) iack_cnt++;
    end
    chk("disabled_no_iack", 32'(iack_cnt), 32'd0);

    // Request present away from a boundary is held off until the boundary cycle.
    drive(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    step();
    drive(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 16'h0600, 1'b0);
    iack_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (iack_a) iack_cnt++;
    end
    chk("no_boundary_no_iack", 32'(iack_cnt), 32'd0);
    instr_boundary = 1'b1;
    step();
    chk("boundary_iack", 32'(iack_a), 32'd1);
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    step();
    chk("wrap_take", 32'(take_b), 32'd1);
    chk("wrap_vector", 32'(vec_b), 32'h0000);
    chk("src1_vector", 32'(vec_a), 32'h0008);
    step();
    reti = 1'b1;
    step();
    reti = 1'b0;
    step();

    // Random traffic against the model, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      reset          = ($urandom_range(0, 149) == 0);
      c_irq          = 2'($urandom_range(0, 3));
      int_en_set     = ($urandom_range(0, 9) == 0);
      int_en_clr     = ($urandom_range(0, 19) == 0);
      instr_boundary = ($urandom_range(0, 1) == 1);
      pc_in          = ADDR_W'($urandom);
      reti           = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
